// File: rtl/data_sram_ctrl.sv
// data_sram_ctrl: sequences one MEM-stage load/store onto the SRAM-like data bus.
// It keeps the pipeline stalled until the bus transaction finishes. Load data is
// then held until the whole pipeline releases its stall.
module data_sram_ctrl #(
    parameter bit ADDR_MAP = 1'b1,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic [3:0]        mem_wen,
    input  logic [1:0]        mem_rsize,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_except,
    input  logic              longest_stall,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              d_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_req;
    logic                r_wr;
    logic [1:0]          r_size;
    logic [31:0]         r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_go;
    logic                w_wr;
    logic [1:0]          w_size;
    logic [31:0]         w_paddr;
    logic                w_stall;

    assign w_go = mem_en & ~mem_except;

    // Decode transfer size and direction from the byte strobes.
    always_comb begin
        w_wr   = 1'b1;
        w_size = 2'd2;
        case (mem_wen)
            4'b1111:                            begin w_wr = 1'b1; w_size = 2'd2;      end
            4'b0011, 4'b1100:                   begin w_wr = 1'b1; w_size = 2'd1;      end
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin w_wr = 1'b1; w_size = 2'd0;      end
            4'b0000:                            begin w_wr = 1'b0; w_size = mem_rsize; end
            // Malformed strobe patterns fall back to a full-word write.
            default:                            begin w_wr = 1'b1; w_size = 2'd2;      end
        endcase
    end

    // Translate kseg0/kseg1 virtual addresses to physical by clearing the top three bits.
    always_comb begin
        w_paddr = mem_addr;
        if (ADDR_MAP && (mem_addr[31:30] == 2'b10)) begin
            w_paddr = {3'b000, mem_addr[28:0]};
        end else begin
            w_paddr = mem_addr;
        end
    end

    // Stall request: raised combinationally on a new access so the pipeline freezes at once.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = w_go;
            S_REQ:   w_stall = 1'b1;
            S_WAIT:  w_stall = 1'b1;
            S_DONE:  w_stall = 1'b0;
            default: w_stall = 1'b0;
        endcase
    end

    // Access sequencer with registered bus fields and load-data holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 32'd0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_req   <= 1'b1;
                        r_wr    <= w_wr;
                        r_size  <= w_size;
                        r_addr  <= w_paddr;
                        r_wdata <= mem_wdata;
                        r_state <= S_REQ;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    // A late exception cannot cancel the request; it completes normally.
                    if (data_addr_ok) begin
                        r_req <= 1'b0;
                        if (data_data_ok) begin
                            if (!r_wr) begin
                                r_rdata <= data_rdata;
                            end
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_state <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        if (!r_wr) begin
                            r_rdata <= data_rdata;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    // Stay here while any stall is up so the same instruction is not reissued.
                    if (!longest_stall) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rdata  = r_rdata;
    assign d_stall    = w_stall;
    assign data_req   = r_req;
    assign data_wr    = r_wr;
    assign data_size  = r_size;
    assign data_addr  = r_addr;
    assign data_wdata = r_wdata;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Self-checking bench for data_sram_ctrl. A bus responder applies programmed
// addr_ok/data_ok delays, and a transaction-level model predicts the outcome.
module tb_data_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [1:0]  mem_rsize;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_except;
    logic        ext_stall;
    logic        longest_stall;
    logic [31:0] mem_rdata;
    logic        d_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic [31:0] n_rdata;
    logic        n_stall;
    logic        n_req;
    logic        n_wr;
    logic [1:0]  n_size;
    logic [31:0] n_addr;
    logic [31:0] n_wdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    assign longest_stall = d_stall | ext_stall;

    data_sram_ctrl #(.ADDR_MAP(1'b1), .DATA_W(32)) u_dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_rsize(mem_rsize),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_except(mem_except),
        .longest_stall(longest_stall), .mem_rdata(mem_rdata), .d_stall(d_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    data_sram_ctrl #(.ADDR_MAP(1'b0), .DATA_W(32)) u_dut_nomap (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_rsize(mem_rsize),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_except(mem_except),
        .longest_stall(longest_stall), .mem_rdata(n_rdata), .d_stall(n_stall),
        .data_req(n_req), .data_wr(n_wr), .data_size(n_size), .data_addr(n_addr),
        .data_wdata(n_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    function automatic logic [1:0] f_size(input logic [3:0] w, input logic [1:0] r);
        int ones;
        ones = $countones(w);
        if (ones == 0) return r;
        if (ones == 1) return 2'd0;
        if (ones == 2) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] f_paddr(input logic [31:0] a);
        if (a[31:30] == 2'b10) return a & 32'h1FFF_FFFF;
        return a;
    endfunction

    // One complete access. a_dly: REQ cycles before addr_ok; d_dly: cycles from addr_ok
    // to data_ok; hold: DONE cycles with the external stall raised.
    task automatic run_access(input logic [3:0] wen, input logic [1:0] rsz,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int a_dly, input int d_dly,
                              input int hold, input bit exc_wait, input bit b2b);
        int rq = 0, wc = 0, hc = 0, tot = 0, req_cyc = 0, stall_cyc = 0, rises = 0;
        bit acc = 0, done = 0, done_prev = 0, prev_req = 0, fin = 0;
        logic [1:0]  e_size = f_size(wen, rsz);
        logic        e_wr   = (wen != 4'b0000);
        logic [31:0] e_addr = f_paddr(addr);
        logic [31:0] e_rd   = e_wr ? m_rdata : rdata;
        while (!fin && tot < 60) begin
            @(posedge clk); #1;
            if (tot == 0) begin
                mem_en = 1'b1; mem_except = 1'b0; mem_wen = wen; mem_rsize = rsz;
                mem_addr = addr; mem_wdata = wdata;
            end
            data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom; ext_stall = 1'b0;
            done_prev = done;
            if (data_req) begin
                if (rq == a_dly) begin
                    data_addr_ok = 1'b1; acc = 1;
                    if (d_dly == 0) begin data_data_ok = 1'b1; data_rdata = rdata; done = 1; end
                end
                rq++;
            end else if (acc && !done) begin
                wc++;
                if (exc_wait) mem_except = 1'b1;
                if (wc == d_dly) begin data_data_ok = 1'b1; data_rdata = rdata; done = 1; end
            end else if (done_prev && hc < hold) begin
                ext_stall = 1'b1;
                if (hc == 1) data_data_ok = 1'b1;   // stray data_ok in DONE must be ignored
                hc++;
            end
            #1;
            tot++;
            if (d_stall) stall_cyc++;
            if (data_req) begin
                req_cyc++;
                if (!prev_req) rises++;
                n_cmp++; if (data_addr !== e_addr) begin n_err++; $display("FAIL addr: got %h exp %h", data_addr, e_addr); end
                n_cmp++; if (n_addr !== addr) begin n_err++; $display("FAIL nomap_addr: got %h exp %h", n_addr, addr); end
                n_cmp++; if (data_size !== e_size) begin n_err++; $display("FAIL size: got %0d exp %0d", data_size, e_size); end
                n_cmp++; if (data_wr !== e_wr) begin n_err++; $display("FAIL wr: got %0b exp %0b", data_wr, e_wr); end
                if (e_wr) begin
                    n_cmp++; if (data_wdata !== wdata) begin n_err++; $display("FAIL wdata: got %h exp %h", data_wdata, wdata); end
                end
            end
            prev_req = data_req;
            if (done_prev) begin
                n_cmp++; if (mem_rdata !== e_rd) begin n_err++; $display("FAIL done_rdata: got %h exp %h", mem_rdata, e_rd); end
                if (!d_stall && !ext_stall) fin = 1;
            end
        end
        n_cmp++; if (!fin) begin n_err++; $display("FAIL timeout: got %0d cycles exp %0d", tot, a_dly + d_dly + hold + 3); end
        n_cmp++; if (req_cyc != a_dly + 1) begin n_err++; $display("FAIL req_cycles: got %0d exp %0d", req_cyc, a_dly + 1); end
        n_cmp++; if (stall_cyc != a_dly + d_dly + 2) begin n_err++; $display("FAIL stall_cycles: got %0d exp %0d", stall_cyc, a_dly + d_dly + 2); end
        n_cmp++; if (rises != 1) begin n_err++; $display("FAIL req_count: got %0d exp 1", rises); end
        n_cmp++; if (tot != a_dly + d_dly + hold + 3) begin n_err++; $display("FAIL latency: got %0d exp %0d", tot, a_dly + d_dly + hold + 3); end
        m_rdata = e_rd;
        if (!b2b) begin
            @(posedge clk); #1;
            mem_en = 1'b0; mem_except = 1'b0; ext_stall = 1'b0;
            data_addr_ok = 1'b0; data_data_ok = 1'b0;
            #1;
            n_cmp++; if (mem_rdata !== m_rdata) begin n_err++; $display("FAIL idle_rdata: got %h exp %h", mem_rdata, m_rdata); end
            n_cmp++; if (n_rdata !== m_rdata) begin n_err++; $display("FAIL nomap_rdata: got %h exp %h", n_rdata, m_rdata); end
            n_cmp++; if (data_req !== 1'b0 || d_stall !== 1'b0) begin n_err++; $display("FAIL idle_state: got req %0b stall %0b exp 0 0", data_req, d_stall); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_en = 1'b0; mem_wen = 4'd0; mem_rsize = 2'd0; mem_addr = 32'd0;
        mem_wdata = 32'd0; mem_except = 1'b0; ext_stall = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; #1;
        m_rdata = 32'd0;
        n_cmp++; if ({data_req, data_wr, data_size, d_stall} !== 5'd0) begin n_err++; $display("FAIL reset_ctrl: got %b exp 00000", {data_req, data_wr, data_size, d_stall}); end
        n_cmp++; if ({data_addr, data_wdata, mem_rdata} !== 96'd0) begin n_err++; $display("FAIL reset_data: got %h %h %h exp 0", data_addr, data_wdata, mem_rdata); end
    endtask

    task automatic test_load_word();
        run_access(4'b0000, 2'd2, 32'hBFC0_0010, 32'h0, 32'h1234_5678, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_store_byte();
        run_access(4'b0100, 2'd0, 32'h8000_0002, 32'hABAB_ABAB, 32'hDEAD_BEEF, 2, 3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_store_half_word();
        run_access(4'b1100, 2'd0, 32'hA000_0104, 32'h5A5A_5A5A, 32'h0, 1, 0, 0, 1'b0, 1'b0);
        run_access(4'b1111, 2'd0, 32'h8000_0000, 32'hCAFE_F00D, 32'h0, 0, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_except();
        @(posedge clk); #1;
        mem_en = 1'b1; mem_except = 1'b1; mem_wen = 4'b0000; mem_rsize = 2'd2; mem_addr = 32'h0000_0040;
        #1;
        n_cmp++; if (d_stall !== 1'b0) begin n_err++; $display("FAIL except_stall: got %0b exp 0", d_stall); end
        @(posedge clk); #2;
        n_cmp++; if (data_req !== 1'b0 || d_stall !== 1'b0) begin n_err++; $display("FAIL except_req: got req %0b stall %0b exp 0 0", data_req, d_stall); end
        mem_en = 1'b0; mem_except = 1'b0;
        run_access(4'b0000, 2'd1, 32'h0000_0102, 32'h0, 32'h0000_7777, 0, 2, 0, 1'b1, 1'b0);
    endtask

    task automatic test_hold();
        run_access(4'b0000, 2'd2, 32'h9FC0_1000, 32'h0, 32'h0BAD_CAFE, 1, 1, 4, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        mem_en = 1'b1; mem_except = 1'b0; mem_wen = 4'b0000; mem_rsize = 2'd2; mem_addr = 32'h0000_0200;
        @(posedge clk); #1 data_addr_ok = 1'b1;
        @(posedge clk); #1 data_addr_ok = 1'b0; #1;
        n_cmp++; if (data_req !== 1'b0 || d_stall !== 1'b1) begin n_err++; $display("FAIL wait_state: got req %0b stall %0b exp 0 1", data_req, d_stall); end
        rst = 1'b1; mem_en = 1'b0;
        @(posedge clk); #1 rst = 1'b0; #1;
        m_rdata = 32'd0;
        n_cmp++; if ({data_req, data_wr, data_size, d_stall, data_addr, mem_rdata} !== 69'd0) begin n_err++; $display("FAIL midreset_outputs: got req %0b addr %h rdata %h exp 0", data_req, data_addr, mem_rdata); end
        data_data_ok = 1'b1; data_rdata = 32'hFFFF_0000;
        @(posedge clk); #1 data_data_ok = 1'b0; #1;
        n_cmp++; if (mem_rdata !== 32'd0 || data_req !== 1'b0 || d_stall !== 1'b0) begin n_err++; $display("FAIL late_data_ok: got rdata %h req %0b exp 0 0", mem_rdata, data_req); end
        run_access(4'b0000, 2'd2, 32'h8000_0300, 32'h0, 32'h3141_5926, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] wens [8];
        wens = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[31:30] = 2'b10;
            run_access(wens[$urandom_range(0, 7)], 2'($urandom_range(0, 2)), a, $urandom, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                       1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        run_access(4'b0000, 2'd2, 32'h8000_1000, 32'h0, 32'h1111_2222, 0, 0, 0, 1'b0, 1'b1);
        run_access(4'b0011, 2'd0, 32'h8000_1004, 32'h3333_4444, 32'h0, 0, 0, 0, 1'b0, 1'b1);
        run_access(4'b0000, 2'd0, 32'hA000_1007, 32'h0, 32'h5555_6666, 1, 0, 1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_store_half_word();
        test_except();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
